// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the MIPS-I execution unit: ALU function select and
// HI/LO operation select.
package mips_cpu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_NOR   = 5'd5,
    ALU_SLT   = 5'd6,
    ALU_SLTU  = 5'd7,
    ALU_SLL   = 5'd8,
    ALU_SRL   = 5'd9,
    ALU_SRA   = 5'd10,
    ALU_SLLV  = 5'd11,
    ALU_SRLV  = 5'd12,
    ALU_SRAV  = 5'd13,
    ALU_LUI   = 5'd14,
    ALU_MFHI  = 5'd15,
    ALU_MFLO  = 5'd16,
    ALU_BEQ   = 5'd17,
    ALU_BNE   = 5'd18,
    ALU_BLEZ  = 5'd19,
    ALU_BGTZ  = 5'd20,
    ALU_BLTZ  = 5'd21,
    ALU_BGEZ  = 5'd22,
    ALU_PASSA = 5'd23
  } alu_func_t;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } mult_op_t;

endpackage

// File: rtl/mips_cpu_muldiv_unit.sv
// HI/LO architectural registers with single-cycle multiply, divide and
// move-to operations, committed on the clock edge when write is high.
module mips_cpu_muldiv_unit
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  mult_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        write,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic signed [31:0] a_s;
  logic signed [31:0] den_s;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] den_u;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               div_zero;
  logic               div_ovf;

  assign a_s    = a;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'h0, a} * {32'h0, b};

  // Dividing by 1 in the overflow case yields exactly the required
  // quotient 0x80000000 and remainder 0; the zero-divisor guard only keeps
  // the divider defined, since that case commits nothing.
  assign div_zero = (b == 32'h0);
  assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign den_s    = (div_zero || div_ovf) ? 32'sd1 : $signed(b);
  assign den_u    = div_zero ? 32'h1 : b;
  assign quot_s   = a_s / den_s;
  assign rem_s    = a_s % den_s;
  assign quot_u   = a / den_u;
  assign rem_u    = a % den_u;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (write) begin
      case (mult_op_t'(mult_op))
        MD_MULT: begin
          hi_d = prod_s[63:32];
          lo_d = prod_s[31:0];
        end
        MD_MULTU: begin
          hi_d = prod_u[63:32];
          lo_d = prod_u[31:0];
        end
        MD_DIV: begin
          if (!div_zero) begin
            hi_d = rem_s;
            lo_d = quot_s;
          end
        end
        MD_DIVU: begin
          if (!div_zero) begin
            hi_d = rem_u;
            lo_d = quot_u;
          end
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: begin
          hi_d = hi_q;
          lo_d = lo_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mips_cpu_alu_unit.sv
// Execution unit of the multicycle MIPS-I CPU: combinational ALU and branch
// condition logic, plus the HI/LO multiply/divide block.
module mips_cpu_alu_unit
  import mips_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  alu_func,
  input  logic [2:0]  mult_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shift,
  input  logic        write,
  output logic        condition,
  output logic [31:0] result
);

  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [31:0]        diff;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic signed [31:0] sra_c;
  logic signed [31:0] sra_v;

  mips_cpu_muldiv_unit u_muldiv (
    .clk     (clk),
    .reset   (reset),
    .mult_op (mult_op),
    .a       (a),
    .b       (b),
    .write   (write),
    .hi      (hi),
    .lo      (lo)
  );

  assign a_s   = a;
  assign b_s   = b;
  assign diff  = a - b;
  assign sra_c = b_s >>> shift;
  assign sra_v = b_s >>> a[4:0];

  always_comb begin
    result    = 32'h0;
    condition = 1'b0;
    case (alu_func_t'(alu_func))
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = diff;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_NOR:   result = ~(a | b);
      ALU_SLT:   result = {31'h0, a_s < b_s};
      ALU_SLTU:  result = {31'h0, a < b};
      ALU_SLL:   result = b << shift;
      ALU_SRL:   result = b >> shift;
      ALU_SRA:   result = sra_c;
      ALU_SLLV:  result = b << a[4:0];
      ALU_SRLV:  result = b >> a[4:0];
      ALU_SRAV:  result = sra_v;
      ALU_LUI:   result = {b[15:0], 16'h0};
      ALU_MFHI:  result = hi;
      ALU_MFLO:  result = lo;
      // Branch codes expose a-b on result alongside the taken flag.
      ALU_BEQ: begin
        result    = diff;
        condition = (a == b);
      end
      ALU_BNE: begin
        result    = diff;
        condition = (a != b);
      end
      ALU_BLEZ: begin
        result    = diff;
        condition = a[31] || (a == 32'h0);
      end
      ALU_BGTZ: begin
        result    = diff;
        condition = !a[31] && (a != 32'h0);
      end
      ALU_BLTZ: begin
        result    = diff;
        condition = a[31];
      end
      ALU_BGEZ: begin
        result    = diff;
        condition = !a[31];
      end
      ALU_PASSA: result = a;
      default: begin
        result    = 32'h0;
        condition = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_alu_unit.sv
// Self-checking bench for mips_cpu_alu_unit: directed cases plus randomized
// traffic against an arithmetic reference model of the ALU and HI/LO.
module tb_mips_cpu_alu_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  alu_func;
  logic [2:0]  mult_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  shift;
  logic        write;
  logic        condition;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  mips_cpu_alu_unit dut (
    .clk       (clk),
    .reset     (reset),
    .alu_func  (alu_func),
    .mult_op   (mult_op),
    .a         (a),
    .b         (b),
    .shift     (shift),
    .write     (write),
    .condition (condition),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference ALU: {condition, result} from signed/unsigned integer arithmetic.
  function automatic logic [32:0] ref_alu(input int f, input logic [31:0] ai,
                                          input logic [31:0] bi, input int sh,
                                          input logic [31:0] hi_v, input logic [31:0] lo_v);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          t;
    logic [31:0]     r;
    logic            c;
    sa = $signed(ai);
    sb = $signed(bi);
    ua = ai;
    ub = bi;
    r  = 32'h0;
    c  = 1'b0;
    if (f >= 11 && f <= 13) sh = int'(ai % 32);
    case (f)
      0:  begin t = longint'(ua + ub); r = t[31:0]; end
      1:  begin t = sa - sb; r = t[31:0]; end
      2:  r = ai & bi;
      3:  r = ai | bi;
      4:  r = ai ^ bi;
      5:  r = ~(ai | bi);
      6:  r = (sa < sb) ? 32'd1 : 32'd0;
      7:  r = (ua < ub) ? 32'd1 : 32'd0;
      8, 11: begin t = longint'(ub * (64'd1 << sh)); r = t[31:0]; end
      9, 12: begin t = longint'(ub / (64'd1 << sh)); r = t[31:0]; end
      10, 13: begin
        // floor division by 2^sh equals an arithmetic right shift
        t = (sb >= 0) ? sb / (64'sd1 <<< sh)
                      : -((-sb + (64'sd1 <<< sh) - 1) / (64'sd1 <<< sh));
        r = t[31:0];
      end
      14: begin t = longint'((ub % 65536) * 65536); r = t[31:0]; end
      15: r = hi_v;
      16: r = lo_v;
      17, 18, 19, 20, 21, 22: begin
        t = sa - sb;
        r = t[31:0];
        case (f)
          17: c = (ai == bi);
          18: c = (ai != bi);
          19: c = (sa <= 0);
          20: c = (sa > 0);
          21: c = (sa < 0);
          default: c = (sa >= 0);
        endcase
      end
      23: r = ai;
      default: begin r = 32'h0; c = 1'b0; end
    endcase
    return {c, r};
  endfunction

  task automatic ref_hilo(input int m, input logic [31:0] ai, input logic [31:0] bi,
                          input logic wr, input logic rst);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          p;
    longint          q;
    longint          rm;
    sa = $signed(ai);
    sb = $signed(bi);
    ua = ai;
    ub = bi;
    if (rst) begin
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else if (wr) begin
      case (m)
        1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
        2: begin p = longint'(ua * ub); m_hi = p[63:32]; m_lo = p[31:0]; end
        3: if (bi != 0) begin q = sa / sb; rm = sa % sb; m_lo = q[31:0]; m_hi = rm[31:0]; end
        4: if (bi != 0) begin q = longint'(ua / ub); rm = longint'(ua % ub); m_lo = q[31:0]; m_hi = rm[31:0]; end
        5: m_hi = ai;
        6: m_lo = ai;
        default: ;
      endcase
    end
  endtask

  task automatic apply(input int f, input int m, input logic [31:0] ai, input logic [31:0] bi,
                       input int sh, input logic wr, input logic rst, input string tag,
                       output logic [31:0] res_o, output logic cond_o);
    logic [32:0] exp;
    alu_func = f[4:0];
    mult_op  = m[2:0];
    a        = ai;
    b        = bi;
    shift    = sh[4:0];
    write    = wr;
    reset    = rst;
    #2;
    exp = ref_alu(f, ai, bi, sh, m_hi, m_lo);
    chk({tag, "_res"}, result, exp[31:0]);
    chk({tag, "_cond"}, {31'h0, condition}, {31'h0, exp[32]});
    res_o  = result;
    cond_o = condition;
    @(posedge clk);
    ref_hilo(m, ai, bi, wr, rst);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic        c;
    int          f;
    int          m;
    logic [31:0] ra;
    logic [31:0] rb;

    apply(0, 0, 32'h0, 32'h0, 0, 1'b0, 1'b1, "rst0", r, c);
    apply(0, 1, 32'h5, 32'h7, 0, 1'b1, 1'b1, "rst1", r, c);
    apply(15, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "rst_hi", r, c);
    chk("rst_hi_zero", r, 32'h0);
    apply(16, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "rst_lo", r, c);
    chk("rst_lo_zero", r, 32'h0);

    apply(0, 0, 32'hFFFF_FFFF, 32'h1, 0, 1'b0, 1'b0, "add", r, c);
    chk("add_wrap", r, 32'h0);
    chk("add_cond", {31'h0, c}, 32'h0);
    apply(1, 0, 32'h3, 32'h5, 0, 1'b0, 1'b0, "sub", r, c);
    chk("sub_neg", r, 32'hFFFF_FFFE);
    apply(6, 0, 32'hFFFF_FFFF, 32'h1, 0, 1'b0, 1'b0, "slt", r, c);
    chk("slt_signed", r, 32'h1);
    apply(7, 0, 32'hFFFF_FFFF, 32'h1, 0, 1'b0, 1'b0, "sltu", r, c);
    chk("sltu_unsigned", r, 32'h0);
    apply(10, 0, 32'h0, 32'h8000_0000, 4, 1'b0, 1'b0, "sra", r, c);
    chk("sra_sign", r, 32'hF800_0000);
    apply(12, 0, 32'd36, 32'hF0, 0, 1'b0, 1'b0, "srlv", r, c);
    chk("srlv_a40", r, 32'h0F);
    apply(14, 0, 32'h0, 32'h1234, 0, 1'b0, 1'b0, "lui", r, c);
    chk("lui_val", r, 32'h1234_0000);

    apply(17, 0, 32'h7, 32'h7, 0, 1'b0, 1'b0, "beq", r, c);
    chk("beq_taken", {31'h0, c}, 32'h1);
    apply(18, 0, 32'h7, 32'h7, 0, 1'b0, 1'b0, "bne", r, c);
    chk("bne_not", {31'h0, c}, 32'h0);
    apply(19, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "blez", r, c);
    chk("blez_zero", {31'h0, c}, 32'h1);
    apply(20, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "bgtz", r, c);
    chk("bgtz_zero", {31'h0, c}, 32'h0);
    apply(21, 0, 32'h8000_0000, 32'h0, 0, 1'b0, 1'b0, "bltz", r, c);
    chk("bltz_min", {31'h0, c}, 32'h1);
    apply(22, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "bgez", r, c);
    chk("bgez_zero", {31'h0, c}, 32'h1);

    apply(15, 1, 32'hFFFF_FFFE, 32'h3, 0, 1'b1, 1'b0, "mult", r, c);
    chk("mult_old_hi", r, 32'h0);
    apply(15, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "mult_hi", r, c);
    chk("mult_hi_val", r, 32'hFFFF_FFFF);
    apply(16, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "mult_lo", r, c);
    chk("mult_lo_val", r, 32'hFFFF_FFFA);
    apply(0, 2, 32'hFFFF_FFFE, 32'h3, 0, 1'b1, 1'b0, "multu", r, c);
    apply(15, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "multu_hi", r, c);
    chk("multu_hi_val", r, 32'h2);
    apply(16, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "multu_lo", r, c);
    chk("multu_lo_val", r, 32'hFFFF_FFFA);

    apply(0, 3, 32'hFFFF_FFF9, 32'h2, 0, 1'b1, 1'b0, "div", r, c);
    apply(16, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "div_lo", r, c);
    chk("div_lo_val", r, 32'hFFFF_FFFD);
    apply(15, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "div_hi", r, c);
    chk("div_hi_val", r, 32'hFFFF_FFFF);
    apply(0, 4, 32'h7, 32'h2, 0, 1'b1, 1'b0, "divu", r, c);
    apply(0, 4, 32'h9, 32'h0, 0, 1'b1, 1'b0, "divu0", r, c);
    apply(16, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "divu_lo", r, c);
    chk("divu_lo_val", r, 32'h3);
    apply(15, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "divu_hi", r, c);
    chk("divu_hi_val", r, 32'h1);
    apply(0, 3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, "divovf", r, c);
    apply(16, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "divovf_lo", r, c);
    chk("divovf_lo_val", r, 32'h8000_0000);
    apply(15, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "divovf_hi", r, c);
    chk("divovf_hi_val", r, 32'h0);

    apply(0, 5, 32'hDEAD_BEEF, 32'h0, 0, 1'b1, 1'b1, "mthi_rst", r, c);
    apply(15, 5, 32'hDEAD_BEEF, 32'h0, 0, 1'b1, 1'b0, "mthi_go", r, c);
    chk("mthi_after_rst", r, 32'h0);
    apply(15, 0, 32'h0, 32'h0, 0, 1'b0, 1'b0, "mthi_rd", r, c);
    chk("mthi_val", r, 32'hDEAD_BEEF);

    for (int i = 0; i < 600; i++) begin
      f  = int'($urandom_range(0, 31));
      m  = int'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = ra;
        3: ra = 32'h0;
        4: ra = {28'h0, ra[3:0]};
        default: ;
      endcase
      apply(f, m, ra, rb, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0), "rnd", r, c);
      if (i % 4 == 0) begin
        apply(15, 0, ra, rb, 0, 1'b0, 1'b0, "rnd_hi", r, c);
        apply(16, 0, ra, rb, 0, 1'b0, 1'b0, "rnd_lo", r, c);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
